operand_streamer: RTL and testbench
===================================

Name: operand_streamer

Overview:
- Source-side producer for the matrix core's sink stream interface.
- On a start command it reads a contiguous block of operand words from a synchronous-read operand memory, then streams them over the valid/ready interface.
- Weight words go out first, then vector-input words; each word is tagged with its kind, and the final word is marked.
- Sits between the operand SRAM and matrix_core's snk_vld/snk_rdy/snk_data inputs.

Parameters:
- DATA_WIDTH, 32, width of the memory read data and stream data.
- ADDR_WIDTH, 10, operand memory address width.
- LEN_WIDTH, 8, width of the per-phase word counts.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first operand address, captured on start.
- n_weights  input  LEN_WIDTH  weight word count, captured on start.
- n_vectors  input  LEN_WIDTH  vector word count, captured on start.
- busy  output  1  high from the start-capture edge until the done pulse.
- done  output  1  one-cycle pulse; the command has completed.
- mem_rd_en  output  1  memory read strobe.
- mem_rd_addr  output  ADDR_WIDTH  memory read address.
- mem_rd_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- src_vld  output  1  stream word valid.
- src_rdy  input  1  downstream ready.
- src_data  output  DATA_WIDTH  stream word.
- src_kind  output  1  0 = weight word, 1 = vector word.
- src_last  output  1  final word of the command.
- checksum  output  DATA_WIDTH  see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE, buffer emptied, in-flight read discarded.
  - busy, done, mem_rd_en, src_vld, src_kind, src_last = 0.
  - src_data, mem_rd_addr, checksum = 0.
- FSM states: IDLE, WEIGHTS, VECTORS, DRAIN.
  - IDLE: start=1 captures base_addr, n_weights and n_vectors. Next state is WEIGHTS if n_weights>0; else VECTORS if n_vectors>0; else DRAIN.
  - WEIGHTS: one read per issue slot. After the last weight read is issued, go to VECTORS, or DRAIN if n_vectors=0.
  - VECTORS: after the last vector read is issued, go to DRAIN.
  - DRAIN: no reads. Once the buffer is empty and no read is in flight, pulse done for 1 cycle and return to IDLE.
- start outside IDLE: ignored; no effect on the current command.
- Addressing:
  - Weights use base_addr .. base_addr+n_weights-1.
  - Vectors continue contiguously at base_addr+n_weights.
  - Addresses wrap modulo 2^ADDR_WIDTH.
- Buffering: 2-entry output buffer plus the 1-cycle memory latency.
  - A read is issued only if (buffer occupancy + in-flight reads) < 2.
  - The buffer never overflows.
- Stream rules:
  - A transfer occurs when src_vld && src_rdy.
  - While src_vld=1 and src_rdy=0, src_data/src_kind/src_last hold stable and src_vld does not drop.
  - src_vld never depends combinationally on src_rdy.
  - src_kind is carried with each word from its issue phase.
  - src_last=1 only on the final word of the command: the last vector word, or the last weight word when n_vectors=0.
- Timing:
  - start accepted at edge T.
  - First mem_rd_en is high in the cycle after T.
  - First src_vld is high 2 cycles after T.
  - With src_rdy held at 1: one word per cycle, no bubbles.
  - done pulses in the cycle after the src_last transfer.
- Zero-length command (n_weights=0 and n_vectors=0): no reads, no transfers; done pulses 2 cycles after start.
- Counts are unsigned; the maximum per phase is 2^LEN_WIDTH-1 words.
- busy is high in every cycle in which the FSM is not IDLE.

Optional Feature:
- Macro: OPERAND_STREAMER_CHECKSUM_EN.
- Defined:
  - checksum = XOR of every src_data word transferred in the current command.
  - Cleared to 0 when start is accepted.
  - Holds its final value from the done pulse until the next accepted start.
- Undefined: checksum is tied to 0 and no accumulator logic is built.

Test Plan:
- base=0x010, nw=3, nv=2, memory[a]=a, src_rdy=1 -> data 0x10,0x11,0x12 with kind=0, then 0x13,0x14 with kind=1; last only on 0x14; 5 back-to-back transfers; done 1 cycle after last.
- Same command, src_rdy toggling 1,0,0,1,... -> words identical and in order; outputs stable while stalled; mem_rd_en never issued with 2 entries outstanding.
- base=0x3FE, nw=2, nv=2 -> addresses 0x3FE,0x3FF,0x000,0x001 (wrap).
- nw=0, nv=0 -> zero transfers; done 2 cycles after start. nw=4, nv=0 -> last on 4th weight, all kind=0.
- Second start pulsed mid-command -> ignored; only the original word count is transferred.
- rst_n dropped mid-stream with src_vld=1 -> all outputs 0 immediately; after release a new start=1 streams correctly from base. With OPERAND_STREAMER_CHECKSUM_EN, words 0x5,0x3,0xF -> checksum 0x9.

Source files
------------

// File: rtl/operand_streamer.sv
// Operand streamer: reads a weight block then a vector block from operand memory and streams them out.
// Optional XOR checksum of transferred words is built when OPERAND_STREAMER_CHECKSUM_EN is defined.
module operand_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  n_weights,
  input  logic [LEN_WIDTH-1:0]  n_vectors,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  src_vld,
  input  logic                  src_rdy,
  output logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_kind,
  output logic                  src_last,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, WEIGHTS, VECTORS, DRAIN} state_e;

  typedef struct packed {
    logic                  kind;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  nv_q, nv_d;
  logic                  infl_q, infl_d;
  logic                  infl_kind_q, infl_kind_d;
  logic                  infl_last_q, infl_last_d;
  logic [1:0]            occ_q, occ_d;
  word_t                 buf_q [2];
  word_t                 buf_d [2];
  logic                  done_q, done_d;

  word_t                 in_word;
  word_t                 q [3];
  logic [1:0]            total;
  logic                  pop;
  logic                  issue;

  // Returning read data joins the queue behind buffered words; an empty buffer shows it directly.
  always_comb begin
    in_word = '{kind: infl_kind_q, last: infl_last_q, data: mem_rd_data};
    q[0] = buf_q[0];
    q[1] = buf_q[1];
    q[2] = in_word;
    if (occ_q == 2'd0) begin
      q[0] = in_word;
    end else if (occ_q == 2'd1) begin
      q[1] = in_word;
    end
    total = occ_q + {1'b0, infl_q};
    pop   = (total != 2'd0) && src_rdy;
    occ_d = pop ? (total - 2'd1) : total;
    buf_d[0] = pop ? q[1] : q[0];
    buf_d[1] = pop ? q[2] : q[1];
    issue = ((state_q == WEIGHTS) || (state_q == VECTORS)) && (total < 2'd2);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    nv_d        = nv_q;
    infl_d      = issue;
    infl_kind_d = infl_kind_q;
    infl_last_d = infl_last_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          nv_d   = n_vectors;
          if (n_weights != '0) begin
            state_d = WEIGHTS;
            cnt_d   = n_weights;
          end else if (n_vectors != '0) begin
            state_d = VECTORS;
            cnt_d   = n_vectors;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      WEIGHTS: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          cnt_d       = cnt_q - LEN_WIDTH'(1);
          infl_kind_d = 1'b0;
          infl_last_d = (cnt_q == LEN_WIDTH'(1)) && (nv_q == '0);
          if (cnt_q == LEN_WIDTH'(1)) begin
            if (nv_q != '0) begin
              state_d = VECTORS;
              cnt_d   = nv_q;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end
      VECTORS: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          cnt_d       = cnt_q - LEN_WIDTH'(1);
          infl_kind_d = 1'b1;
          infl_last_d = (cnt_q == LEN_WIDTH'(1));
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Finish on the edge that empties the pipeline so done follows the last transfer directly.
        if (occ_d == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      nv_q        <= '0;
      infl_q      <= 1'b0;
      infl_kind_q <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= 2'd0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      nv_q        <= nv_d;
      infl_q      <= infl_d;
      infl_kind_q <= infl_kind_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q;
  assign src_vld     = (total != 2'd0);
  assign src_data    = src_vld ? q[0].data : '0;
  assign src_kind    = src_vld ? q[0].kind : 1'b0;
  assign src_last    = src_vld ? q[0].last : 1'b0;

`ifdef OPERAND_STREAMER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if ((state_q == IDLE) && start) begin
      cks_d = '0;
    end else if (pop) begin
      cks_d = cks_q ^ q[0].data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_operand_streamer.sv
// Self-checking bench for operand_streamer: table of commands, scoreboard of expected stream words,
// plus a hand-written mid-stream reset sequence.
module tb_operand_streamer;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 8;
`ifdef OPERAND_STREAMER_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] n_weights = '0;
  logic [LW-1:0] n_vectors = '0;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          src_vld;
  logic          src_rdy = 1'b0;
  logic [DW-1:0] src_data;
  logic          src_kind;
  logic          src_last;
  logic [DW-1:0] checksum;

  logic [DW-1:0] mem [1<<AW];

  typedef struct packed {
    logic          kind;
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] nw;
    logic [LW-1:0] nv;
    int            rdy_mode;
    int            exp_done;
    bit            inject;
  } vec_t;

  word_t sb_q[$];
  vec_t  vecs[8];
  int    checks = 0;
  int    failures = 0;

  operand_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .n_weights(n_weights), .n_vectors(n_vectors), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .src_vld(src_vld), .src_rdy(src_rdy), .src_data(src_data),
    .src_kind(src_kind), .src_last(src_last), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Synchronous-read operand memory with one cycle of latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, {busy, done, mem_rd_en, src_vld, src_kind, src_last}, 0);
    checkOutput({tag, "_src_data"}, src_data, 0);
    checkOutput({tag, "_rd_addr"}, mem_rd_addr, 0);
    checkOutput({tag, "_checksum"}, checksum, 0);
  endtask

  // Runs one command to completion; expected words are queued at start and matched per transfer
  task automatic applyStimulus(input vec_t v, input int idx);
    word_t         w;
    word_t         prev_w;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_cks;
    int            nexp, issued, xfers, done_k;
    bit            prev_stall;
    exp_cks = '0; nexp = 0; issued = 0; xfers = 0; done_k = 0; prev_stall = 1'b0; prev_w = '0;
    sb_q.delete();
    for (int i = 0; i < int'(v.nw); i++) begin
      a = v.base + AW'(i);
      w = '{kind: 1'b0, last: (v.nv == 0) && (i == int'(v.nw) - 1), data: mem[a]};
      sb_q.push_back(w);
      nexp++;
    end
    for (int i = 0; i < int'(v.nv); i++) begin
      a = v.base + AW'(v.nw) + AW'(i);
      w = '{kind: 1'b1, last: (i == int'(v.nv) - 1), data: mem[a]};
      sb_q.push_back(w);
      nexp++;
    end
    start = 1'b1; base_addr = v.base; n_weights = v.nw; n_vectors = v.nv;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      case (v.rdy_mode)
        0: src_rdy = 1'b1;
        1: src_rdy = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
        default: src_rdy = 1'($urandom_range(0, 1));
      endcase
      if (v.inject && k == 3) begin
        start = 1'b1; base_addr = AW'(10'h300); n_weights = 8'd9; n_vectors = 8'd9;
      end
      if (v.inject && k == 4) start = 1'b0;
      @(negedge clk);
      if (k == 1) checkOutput($sformatf("v%0d_busy", idx), busy, 1);
      if (k == 1 && nexp > 0) checkOutput($sformatf("v%0d_first_rd_en", idx), mem_rd_en, 1);
      if (k == 2 && nexp > 0 && v.rdy_mode == 0)
        checkOutput($sformatf("v%0d_first_vld", idx), src_vld, 1);
      if (prev_stall)
        checkOutput($sformatf("v%0d_stall_hold", idx), {src_vld, src_kind, src_last, src_data}, {1'b1, prev_w});
      if (mem_rd_en) begin
        checkOutput($sformatf("v%0d_outstanding", idx), (issued - xfers) < 2, 1);
        issued++;
      end
      prev_stall = src_vld && !src_rdy;
      prev_w = '{kind: src_kind, last: src_last, data: src_data};
      if (src_vld && src_rdy) begin
        xfers++;
        if (sb_q.size() == 0) begin
          checkOutput($sformatf("v%0d_extra_xfer", idx), xfers, nexp);
        end else begin
          w = sb_q.pop_front();
          checkOutput($sformatf("v%0d_word%0d", idx, xfers - 1), {src_kind, src_last, src_data}, w);
          exp_cks ^= w.data;
        end
      end
      if (done) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_k == 0) checkOutput($sformatf("v%0d_done_timeout", idx), done, 1);
    else if (v.exp_done != 0) checkOutput($sformatf("v%0d_done_cycle", idx), done_k, v.exp_done);
    checkOutput($sformatf("v%0d_xfer_count", idx), xfers, nexp);
    checkOutput($sformatf("v%0d_sb_empty", idx), sb_q.size(), 0);
    checkOutput($sformatf("v%0d_checksum", idx), checksum, CKS_EN ? exp_cks : '0);
    @(negedge clk);
    checkOutput($sformatf("v%0d_done_pulse", idx), {done, busy}, 0);
    checkOutput($sformatf("v%0d_checksum_hold", idx), checksum, CKS_EN ? exp_cks : '0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    mem[10'h100] = 32'h5;
    mem[10'h101] = 32'h3;
    mem[10'h102] = 32'hF;

    vecs[0] = '{10'h010, 8'd3, 8'd2, 0, 7, 1'b0};
    vecs[1] = '{10'h010, 8'd3, 8'd2, 1, 0, 1'b0};
    vecs[2] = '{10'h3FE, 8'd2, 8'd2, 0, 6, 1'b0};
    vecs[3] = '{10'h000, 8'd0, 8'd0, 0, 2, 1'b0};
    vecs[4] = '{10'h020, 8'd4, 8'd0, 0, 6, 1'b0};
    vecs[5] = '{10'h080, 8'd3, 8'd1, 0, 6, 1'b1};
    vecs[6] = '{10'h100, 8'd3, 8'd0, 0, 5, 1'b0};
    vecs[7] = '{10'h200, 8'd6, 8'd5, 2, 0, 1'b0};

    #12;
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Drop reset while a word is stalled on the stream, then restart cleanly
    start = 1'b1; base_addr = 10'h040; n_weights = 8'd3; n_vectors = 8'd2; src_rdy = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("vld_before_reset", src_vld, 1);
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus('{10'h050, 8'd2, 8'd1, 0, 5, 1'b0}, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
